// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared definitions for the RV32 fetch stage: datapath width, RV32I
//   major opcodes, the canonical NOP, the fetch FSM state type and the
//   IF/ID register payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_R    = 7'b0110011,
    OP_I    = 7'b0010011,
    OP_S    = 7'b0100011,
    OP_B    = 7'b1100011,
    OP_J    = 7'b1101111,
    OP_U    = 7'b0110111,
    OP_LW   = 7'b0000011,
    OP_JALR = 7'b1100111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Empty IF/ID slot: NOP with zeroed addresses, not a real instruction.
  function automatic if_id_t bubble_entry(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id.sv
// pipe_reg_if_id
//   IF/ID pipeline register.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, loads a bubble
//   i_en     : load i_d on the next edge
//   i_clr    : synchronous clear to bubble, overrides i_en
//   i_d      : incoming fetch payload
//   o_q      : registered payload presented to decode
module pipe_reg_if_id
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_en,
  input  logic   i_clr,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= bubble_entry(BUBBLE_INSTR);
    end else if (i_clr) begin
      r_q <= bubble_entry(BUBBLE_INSTR);
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage: PC register, boot/run/hold FSM, IF/ID
//   register and a counter of valid instructions handed to decode.
//   clk, rst_n          : clock, asynchronous active-low reset
//   StallF, StallD      : hold PC / hold IF/ID
//   FlushD              : bubble into IF/ID
//   PCSrcE, PCTargetE   : redirect from EX (target word-aligned on load)
//   InstrF              : instruction memory data for PCF
//   PCF                 : fetch address
//   InstrD, PCD,
//   PCPlus4D, ValidD    : decode-stage instruction and its addresses
//   opD, funct3D        : InstrD fields for the control unit
//   FetchCount          : number of valid instructions loaded into D
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [6:0]  opD,
  output logic [2:0]  funct3D,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] FetchCount
);

  import fetch_stage_pkg::*;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_fetch_count;

  logic [XLEN-1:0] w_pcplus4f;
  logic [XLEN-1:0] w_pc_next;
  logic            w_boot;
  logic            w_ifid_clr;
  logic            w_ifid_en;
  logic            w_load;
  if_id_t          w_ifid_d;
  if_id_t          w_ifid_q;

  assign w_pcplus4f = r_pcf + 32'd4;
  assign w_boot     = (r_state == ST_BOOT);

  // RUN and HOLD share one IF/ID rule (flush > stall > load); the FSM only
  // records whether the register is currently being held.
  assign w_ifid_clr = w_boot | FlushD;
  assign w_ifid_en  = ~StallD;
  assign w_load     = ~w_ifid_clr & w_ifid_en;

  always_comb begin
    w_pc_next = r_pcf;
    if (!w_boot) begin
      if (PCSrcE) begin
        w_pc_next = {PCTargetE[XLEN-1:2], 2'b00};
      end else if (!StallF) begin
        w_pc_next = w_pcplus4f;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pcf         <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pcf <= w_pc_next;
      if (w_load) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN:  if (StallD && !FlushD) r_state <= ST_HOLD;
        ST_HOLD: if (FlushD || !StallD) r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  always_comb begin
    w_ifid_d          = '0;
    w_ifid_d.instr    = InstrF;
    w_ifid_d.pc       = r_pcf;
    w_ifid_d.pc_plus4 = w_pcplus4f;
    w_ifid_d.valid    = 1'b1;
  end

  pipe_reg_if_id #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_ifid_en),
    .i_clr (w_ifid_clr),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );

  assign PCF        = r_pcf;
  assign InstrD     = w_ifid_q.instr;
  assign PCD        = w_ifid_q.pc;
  assign PCPlus4D   = w_ifid_q.pc_plus4;
  assign ValidD     = w_ifid_q.valid;
  assign opD        = w_ifid_q.instr[6:0];
  assign funct3D    = w_ifid_q.instr[14:12];
  assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
  logic [6:0]  opD;
  logic [2:0]  funct3D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .opD(opD),
    .funct3D(funct3D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchCount(FetchCount)
  );

  // Address-hashed instruction ROM; combinational on the fetch address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ {a[15:0], 16'h5A93};
    return h;
  endfunction
  assign InstrF = rom(PCF);

  typedef struct {
    logic [31:0] pcf, instr, pcd, pcp4d, cnt;
    logic        valid;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: architectural state of the fetch stage
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4d, m_cnt;
  logic        m_valid, m_boot;

  task automatic m_bubble();
    m_instr = NOP; m_pcd = '0; m_pcp4d = '0; m_valid = 1'b0;
  endtask

  task automatic m_reset();
    m_pc = RST_PC; m_cnt = '0; m_boot = 1'b1;
    m_bubble();
  endtask

  task automatic push_exp();
    exp_t e;
    e.pcf = m_pc; e.instr = m_instr; e.pcd = m_pcd;
    e.pcp4d = m_pcp4d; e.cnt = m_cnt; e.valid = m_valid;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge or reset assertion.
  initial begin
    exp_t e;
    logic [31:0] ei;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ei = e.instr;
        chk("PCF",        PCF,        e.pcf);
        chk("InstrD",     InstrD,     e.instr);
        chk("PCD",        PCD,        e.pcd);
        chk("PCPlus4D",   PCPlus4D,   e.pcp4d);
        chk("ValidD",     {31'd0, ValidD}, {31'd0, e.valid});
        chk("FetchCount", FetchCount, e.cnt);
        chk("opD",        {25'd0, opD},     {25'd0, ei[6:0]});
        chk("funct3D",    {29'd0, funct3D}, {29'd0, ei[14:12]});
      end
    end
  end

  // Called at a negedge: drive one cycle of inputs, predict, advance.
  task automatic step(input logic sf, input logic sd, input logic fd,
                      input logic ps, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    if (m_boot) begin
      m_bubble();
      m_boot = 1'b0;
    end else begin
      if (fd) begin
        m_bubble();
      end else if (!sd) begin
        m_instr = rom(m_pc); m_pcd = m_pc; m_pcp4d = m_pc + 32'd4;
        m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
      if (ps)       m_pc = tgt & 32'hFFFF_FFFC;
      else if (!sf) m_pc = m_pc + 32'd4;
    end
    push_exp();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset mid-cycle, hold with junk inputs, release.
  task automatic async_reset(input int unsigned hold_cycles);
    m_reset();
    push_exp();
    #2 rst_n = 1'b0;
    for (int unsigned k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      StallF = 1'($urandom); StallD = 1'($urandom); FlushD = 1'($urandom);
      PCSrcE = 1'($urandom); PCTargetE = $urandom;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_step();
    logic sf, sd, fd, ps;
    logic [31:0] tgt;
    sf = ($urandom_range(0, 4) == 0);
    sd = ($urandom_range(0, 4) == 0);
    fd = ($urandom_range(0, 9) == 0);
    ps = ($urandom_range(0, 9) == 0);
    tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
    step(sf, sd, fd, ps, tgt);
  endtask

  initial begin
    // Power-on reset
    m_reset();
    push_exp();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean startup: BOOT bubble, then PCD=0, then PCD=4 / PCF=8 / count=2
    repeat (4) step(0, 0, 0, 0, '0);

    // Redirect wins over StallF; low target bits dropped
    step(1, 0, 0, 1, 32'h0000_0103);
    step(0, 0, 0, 0, '0);

    // Freeze at PCD=0x10 for three cycles, then resume
    step(0, 0, 0, 1, 32'h0000_0010);
    step(0, 0, 0, 0, '0);
    repeat (3) step(1, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // Flush beats stall
    step(0, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);

    // PC wrap at the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 0, 0, '0);

    // Reset arriving mid-cycle while holding, with a redirect pending
    step(1, 1, 0, 0, '0);
    StallF = 1'b1; StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
    async_reset(2);
    repeat (3) step(0, 0, 0, 0, '0);

    // Randomized traffic with occasional reset pulses
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset($urandom_range(0, 2));
      else rand_step();
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), instruction presented in D when the IF/ID register is empty or flushed.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 StallF  input  1  hold PC this cycle.
REQ-006 StallD  input  1  hold IF/ID register this cycle.
REQ-007 FlushD  input  1  load bubble into IF/ID register this cycle.
REQ-008 PCSrcE  input  1  taken branch/jump resolved in EX; redirect PC.
REQ-009 PCTargetE  input  32  redirect target address.
REQ-010 InstrF  input  32  instruction-memory read data for PCF (combinational memory, same cycle).
REQ-011 PCF  output  32  current fetch address to instruction memory.
REQ-012 InstrD  output  32  decode-stage instruction.
REQ-013 opD  output  7  InstrD[6:0], feeds Control_Unit op.
REQ-014 funct3D  output  3  InstrD[14:12], feeds Control_Unit funct3.
REQ-015 PCD  output  32  address of InstrD.
REQ-016 PCPlus4D  output  32  PCD + 4.
REQ-017 ValidD  output  1  InstrD is a real fetched instruction (not bubble).
REQ-018 FetchCount  output  32  count of valid instructions loaded into D.

Function
REQ-019 PCPlus4F = PCF + 4, modulo 2^32; carry discarded (32'hFFFF_FFFC wraps to 0).
REQ-020 PC next-value priority: PCSrcE -> PCTargetE; else StallF -> hold; else PCPlus4F.
REQ-021 PCSrcE with StallF both high: redirect wins, PC loads PCTargetE.
REQ-022 PCTargetE bits [1:0] forced to 2'b00 when loaded into PC.
REQ-023 FSM states: BOOT, RUN, HOLD.
REQ-024 BOOT: entered on reset; lasts exactly one clock after rst_n deasserts; PC stays RESET_PC; IF/ID loads bubble; next state RUN.
REQ-025 RUN: IF/ID loads {InstrF, PCF, PCPlus4F, valid=1} unless FlushD or StallD; StallD & ~FlushD -> HOLD.
REQ-026 HOLD: IF/ID retains contents; ~StallD -> RUN and load occurs that edge; FlushD -> RUN with bubble.
REQ-027 IF/ID priority: FlushD over StallD over load.
REQ-028 Bubble: InstrD = NOP_INSTR, ValidD = 0, PCD and PCPlus4D = 0.
REQ-029 FetchCount increments by 1 on each edge where a valid instruction is loaded into IF/ID; wraps 32'hFFFF_FFFF -> 0; unchanged on hold, flush, BOOT.
REQ-030 opD, funct3D purely combinational from InstrD; zero latency.
REQ-031 Fetch-to-decode latency: one cycle (InstrF sampled at edge N appears on InstrD after edge N).

Reset
REQ-032 rst_n low asynchronously sets PCF = RESET_PC, InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0, FetchCount = 0, state = BOOT.
REQ-033 Reset asserted mid-stall or mid-redirect discards pending redirect and held instruction; no state survives.
REQ-034 All inputs ignored while rst_n low.

Structure
REQ-035 Shared package holds: opcode constants (R/I/S/B/J/U/LW/JALR), NOP_INSTR, XLEN = 32, FSM state encoding (2 bits).
REQ-036 One sub-module pipe_reg_if_id (enable + synchronous clear + asynchronous active-low reset) holds the IF/ID register; PC register and FSM live in fetch_stage.

Verification
REQ-037 Reset release, StallF=StallD=FlushD=PCSrcE=0, InstrF=PC-indexed ROM -> edge 1: ValidD=0 (BOOT); edge 2: PCD=0, ValidD=1; edge 3: PCD=4, PCF=8, FetchCount=2.
REQ-038 PCSrcE=1, PCTargetE=32'h0000_0103, StallF=1 same cycle -> next PCF=32'h0000_0100.
REQ-039 StallF=StallD=1 for 3 cycles at PCD=0x10 -> PCD, InstrD, PCF, FetchCount frozen; release -> PCD=0x14 next edge.
REQ-040 FlushD=1 and StallD=1 together -> InstrD=32'h0000_0013, ValidD=0, FetchCount unchanged.
REQ-041 PCF=32'hFFFF_FFFC running -> next PCF=0, PCPlus4D of that instruction = 0.
REQ-042 rst_n pulsed low mid-cycle during HOLD -> outputs reach reset values immediately, before the next clk edge; one BOOT cycle follows release.
